// File: rtl/axi_lsu_master.sv
// Load/store unit front end: turns single core requests into AXI-Lite
// transactions. It handles byte/half/word lane steering, rejects misaligned
// or illegal sizes locally, and gives up with an error after a cycle budget.
module axi_lsu_master #(
  parameter int unsigned AXI_AWIDTH     = 32,
  parameter int unsigned AXI_DWIDTH     = 32,
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic                      AXI_ACLK,
  input  logic                      AXI_ARESETN,
  // Core side
  input  logic                      req_valid,
  output logic                      req_ready,
  input  logic                      req_we,
  input  logic [31:0]               req_addr,
  input  logic [31:0]               req_wdata,
  input  logic [1:0]                req_size,
  input  logic                      req_unsigned,
  output logic                      rsp_valid,
  output logic [31:0]               rsp_rdata,
  output logic                      rsp_err,
  // AXI-Lite write channels
  output logic [AXI_AWIDTH-1:0]     AXI_AWADDR,
  output logic                      AXI_AWVALID,
  input  logic                      AXI_AWREADY,
  output logic [AXI_DWIDTH-1:0]     AXI_WDATA,
  output logic [AXI_DWIDTH/8-1:0]   AXI_WSTRB,
  output logic                      AXI_WVALID,
  input  logic                      AXI_WREADY,
  input  logic [1:0]                AXI_BRESP,
  input  logic                      AXI_BVALID,
  output logic                      AXI_BREADY,
  // AXI-Lite read channels
  output logic [AXI_AWIDTH-1:0]     AXI_ARADDR,
  output logic                      AXI_ARVALID,
  input  logic                      AXI_ARREADY,
  input  logic [AXI_DWIDTH-1:0]     AXI_RDATA,
  input  logic [1:0]                AXI_RRESP,
  input  logic                      AXI_RVALID,
  output logic                      AXI_RREADY
);

  // Counter only needs to reach TIMEOUT_CYCLES-1.
  localparam int unsigned CntW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CntW-1:0] CntLast = CntW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {StIdle, StWrite, StRead, StResp} state_e;

  state_e state_q, state_d;

  logic                    req_ready_q, req_ready_d;
  logic                    rsp_valid_q, rsp_valid_d;
  logic [31:0]             rsp_rdata_q, rsp_rdata_d;
  logic                    rsp_err_q, rsp_err_d;
  logic                    awvalid_q, awvalid_d;
  logic                    wvalid_q, wvalid_d;
  logic                    bready_q, bready_d;
  logic                    arvalid_q, arvalid_d;
  logic                    rready_q, rready_d;
  logic [AXI_AWIDTH-1:0]   addr_q, addr_d;
  logic [AXI_DWIDTH-1:0]   wdata_q, wdata_d;
  logic [AXI_DWIDTH/8-1:0] wstrb_q, wstrb_d;
  logic [1:0]              size_q, size_d;
  logic                    uns_q, uns_d;
  logic                    aw_done_q, aw_done_d;
  logic                    w_done_q, w_done_d;
  logic                    b_done_q, b_done_d;
  logic                    berr_q, berr_d;
  logic [CntW-1:0]         cnt_q, cnt_d;

  logic        accept, req_legal;
  logic        aw_hs, w_hs, b_hs, ar_hs, r_hs;
  logic        wr_done, timeout;
  logic [3:0]  strb_map;
  logic [31:0] wdata_map;
  logic [31:0] rd_shift;
  logic [31:0] load_data;

  assign accept    = req_valid && req_ready_q && (state_q == StIdle);
  assign req_legal = (req_size == 2'b00) ||
                     (req_size == 2'b01 && !req_addr[0]) ||
                     (req_size == 2'b10 && req_addr[1:0] == 2'b00);

  assign aw_hs   = awvalid_q && AXI_AWREADY;
  assign w_hs    = wvalid_q && AXI_WREADY;
  assign b_hs    = bready_q && AXI_BVALID;
  assign ar_hs   = arvalid_q && AXI_ARREADY;
  assign r_hs    = rready_q && AXI_RVALID;
  // B may land in the same cycle as AW/W, so look at live handshakes too.
  assign wr_done = (aw_done_q || aw_hs) && (w_done_q || w_hs) && (b_done_q || b_hs);
  assign timeout = (cnt_q == CntLast);

  assign rd_shift = AXI_RDATA >> {addr_q[1:0], 3'b000};

  // Store lane steering: replicate the datum across the bus, strobe the target lanes.
  always_comb begin
    strb_map  = 4'b1111;
    wdata_map = req_wdata;
    case (req_size)
      2'b00: begin
        strb_map  = 4'b0001 << req_addr[1:0];
        wdata_map = {4{req_wdata[7:0]}};
      end
      2'b01: begin
        strb_map  = 4'b0011 << req_addr[1:0];
        wdata_map = {2{req_wdata[15:0]}};
      end
      default: ;
    endcase
  end

  // Load extraction with optional sign extension.
  always_comb begin
    load_data = rd_shift;
    case (size_q)
      2'b00:   load_data = {{24{!uns_q && rd_shift[7]}}, rd_shift[7:0]};
      2'b01:   load_data = {{16{!uns_q && rd_shift[15]}}, rd_shift[15:0]};
      default: ;
    endcase
  end

  // FSM state register.
  always_ff @(posedge AXI_ACLK or negedge AXI_ARESETN) begin
    if (!AXI_ARESETN) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next-state logic.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: begin
        if (accept) begin
          if (!req_legal)  state_d = StResp;
          else if (req_we) state_d = StWrite;
          else             state_d = StRead;
        end
      end
      StWrite: if (wr_done || timeout) state_d = StResp;
      StRead:  if (r_hs || timeout)    state_d = StResp;
      StResp:  state_d = StIdle;
    endcase
  end

  // FSM outputs: next values of every registered output and datapath register.
  always_comb begin
    req_ready_d = (state_d == StIdle);
    rsp_valid_d = 1'b0;
    rsp_rdata_d = rsp_rdata_q;
    rsp_err_d   = rsp_err_q;
    awvalid_d   = awvalid_q;
    wvalid_d    = wvalid_q;
    bready_d    = bready_q;
    arvalid_d   = arvalid_q;
    rready_d    = rready_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    wstrb_d     = wstrb_q;
    size_d      = size_q;
    uns_d       = uns_q;
    aw_done_d   = aw_done_q;
    w_done_d    = w_done_q;
    b_done_d    = b_done_q;
    berr_d      = berr_q;
    cnt_d       = cnt_q;
    unique case (state_q)
      StIdle: begin
        if (accept) begin
          addr_d    = AXI_AWIDTH'(req_addr);
          size_d    = req_size;
          uns_d     = req_unsigned;
          wdata_d   = (req_legal && req_we) ? wdata_map : '0;
          wstrb_d   = (req_legal && req_we) ? strb_map : '0;
          cnt_d     = '0;
          aw_done_d = 1'b0;
          w_done_d  = 1'b0;
          b_done_d  = 1'b0;
          berr_d    = 1'b0;
          awvalid_d = req_legal && req_we;
          wvalid_d  = req_legal && req_we;
          bready_d  = req_legal && req_we;
          arvalid_d = req_legal && !req_we;
          rready_d  = req_legal && !req_we;
          if (!req_legal) begin
            rsp_rdata_d = '0;
            rsp_err_d   = 1'b1;
          end
        end
      end
      StWrite: begin
        cnt_d = cnt_q + 1'b1;
        if (aw_hs) begin
          awvalid_d = 1'b0;
          aw_done_d = 1'b1;
        end
        if (w_hs) begin
          wvalid_d = 1'b0;
          w_done_d = 1'b1;
        end
        // Only the first B response counts.
        if (b_hs && !b_done_q) begin
          b_done_d = 1'b1;
          berr_d   = (AXI_BRESP != 2'b00);
        end
        if (wr_done) begin
          awvalid_d   = 1'b0;
          wvalid_d    = 1'b0;
          bready_d    = 1'b0;
          rsp_rdata_d = '0;
          rsp_err_d   = b_done_q ? berr_q : (AXI_BRESP != 2'b00);
        end else if (timeout) begin
          awvalid_d   = 1'b0;
          wvalid_d    = 1'b0;
          bready_d    = 1'b0;
          rsp_rdata_d = '0;
          rsp_err_d   = 1'b1;
        end
      end
      StRead: begin
        cnt_d = cnt_q + 1'b1;
        if (ar_hs) arvalid_d = 1'b0;
        if (r_hs) begin
          arvalid_d   = 1'b0;
          rready_d    = 1'b0;
          rsp_rdata_d = load_data;
          rsp_err_d   = (AXI_RRESP != 2'b00);
        end else if (timeout) begin
          arvalid_d   = 1'b0;
          rready_d    = 1'b0;
          rsp_rdata_d = '0;
          rsp_err_d   = 1'b1;
        end
      end
      // Response is already latched; flag it on the way back to idle.
      StResp: rsp_valid_d = 1'b1;
    endcase
  end

  // Registered outputs and request capture.
  always_ff @(posedge AXI_ACLK or negedge AXI_ARESETN) begin
    if (!AXI_ARESETN) begin
      req_ready_q <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
      awvalid_q   <= 1'b0;
      wvalid_q    <= 1'b0;
      bready_q    <= 1'b0;
      arvalid_q   <= 1'b0;
      rready_q    <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      wstrb_q     <= '0;
      size_q      <= '0;
      uns_q       <= 1'b0;
      aw_done_q   <= 1'b0;
      w_done_q    <= 1'b0;
      b_done_q    <= 1'b0;
      berr_q      <= 1'b0;
      cnt_q       <= '0;
    end else begin
      req_ready_q <= req_ready_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
      awvalid_q   <= awvalid_d;
      wvalid_q    <= wvalid_d;
      bready_q    <= bready_d;
      arvalid_q   <= arvalid_d;
      rready_q    <= rready_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      wstrb_q     <= wstrb_d;
      size_q      <= size_d;
      uns_q       <= uns_d;
      aw_done_q   <= aw_done_d;
      w_done_q    <= w_done_d;
      b_done_q    <= b_done_d;
      berr_q      <= berr_d;
      cnt_q       <= cnt_d;
    end
  end

  assign req_ready   = req_ready_q;
  assign rsp_valid   = rsp_valid_q;
  assign rsp_rdata   = rsp_rdata_q;
  assign rsp_err     = rsp_err_q;
  assign AXI_AWADDR  = addr_q;
  assign AXI_ARADDR  = addr_q;
  assign AXI_AWVALID = awvalid_q;
  assign AXI_WVALID  = wvalid_q;
  assign AXI_WDATA   = wdata_q;
  assign AXI_WSTRB   = wstrb_q;
  assign AXI_BREADY  = bready_q;
  assign AXI_ARVALID = arvalid_q;
  assign AXI_RREADY  = rready_q;

endmodule
